keypad_scan_display: RTL and testbench
======================================

KEYPAD_SCAN_DISPLAY -- requirements
Module: keypad_scan_display

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 27000, clocks each column stays driven while idle (1 ms at 27 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 270000, clocks a row level must stay stable before it is accepted (10 ms).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 27000, clocks each display digit stays enabled.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 n_reset  in  1  asynchronous active-low reset.
REQ-007 filas_raw  in  4  raw keypad rows, pulled up; low = key in driven column pressed.
REQ-008 cdu  in  12  three BCD digits to display: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 columnas  out  4  column drive, active-low one-hot.
REQ-010 sample  out  4  code of last accepted key, held until next accepted key.
REQ-011 key_valid  out  1  one-cycle pulse when sample is updated.
REQ-012 key_pressed  out  4  debug: one-hot (active-high) of the column whose key is held; 0 when none.
REQ-013 d  out  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-014 a  out  3  digit enables, active-low one-hot; a[0] = units, a[2] = hundreds.

Function
REQ-015 Rows SHALL pass a 2-flop synchronizer before any use.
REQ-016 Scan FSM states SHALL be SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE.
REQ-017 SCAN: columnas SHALL rotate 1110->1101->1011->0111->1110 every SCAN_CYCLES while all synced rows are high.
REQ-018 Any synced row low in SCAN SHALL freeze the column and enter DEBOUNCE_PRESS.
REQ-019 DEBOUNCE_PRESS: rows unchanged for DEBOUNCE_CYCLES SHALL enter HELD; any change SHALL return to SCAN without emitting a code.
REQ-020 On entering HELD, sample SHALL load the key code and key_valid SHALL pulse exactly one cycle.
REQ-021 Key map (row r, column c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; codes 0x0-0x9 digits, 0xA-0xD letters, * = 0xE, # = 0xF.
REQ-022 Several rows low at once SHALL resolve to the lowest-numbered low row.
REQ-023 HELD: all rows high SHALL enter DEBOUNCE_RELEASE; all rows high for DEBOUNCE_CYCLES SHALL return to SCAN at the next column; a relapse SHALL return to HELD with no new pulse.
REQ-024 key_pressed SHALL equal ~columnas while in HELD, else 0.
REQ-025 Display SHALL rotate a 110->101->011->110 every REFRESH_CYCLES.
REQ-026 d SHALL be the combinational decode of the enabled digit: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; 10-15 = blank 0000000.

Reset
REQ-027 While n_reset is low: columnas=1110, sample=0, key_valid=0, key_pressed=0, a=110, FSM=SCAN, all counters 0; reset mid-debounce SHALL discard the pending key.

Structure
REQ-028 Package keypad_display_pkg SHALL hold the FSM state enum, the 4x4 key-code table and the 7-segment table.
REQ-029 Sub-module seg7_decoder (4-bit BCD in, 7-bit segments out, purely combinational) SHALL implement REQ-026; scan FSM, debounce and refresh logic stay in the top module.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, REFRESH_CYCLES=4)
REQ-030 Reset released, rows 1111 -> columnas cycles 1110,1101,1011,0111 every 4 clocks; key_valid never asserted.
REQ-031 Row 1 low while columnas=1011, held 20 clocks -> single key_valid pulse, sample=0x6, key_pressed=0100.
REQ-032 Row 3 low for 3 clocks only, column 0 -> no key_valid; scanning resumes.
REQ-033 Rows 0 and 2 low together, column 3 -> sample=0xA.
REQ-034 cdu=0x125 -> a=110 with d=1101101, a=101 with d=1011011, a=011 with d=0000110, each for 4 clocks.
REQ-035 n_reset pulsed low during DEBOUNCE_PRESS -> outputs at reset values immediately, no key_valid afterwards until a fresh press.

Source files
------------

// File: rtl/keypad_display_pkg.sv
// Shared types and lookup tables for the keypad scanner and 7-segment display.
// Tables are indexed as {row, column} for keys and by BCD value for segments.
package keypad_display_pkg;

   typedef enum logic [1:0] {
      SCAN             = 2'd0,
      DEBOUNCE_PRESS   = 2'd1,
      HELD             = 2'd2,
      DEBOUNCE_RELEASE = 2'd3
   } scan_state_t;

   // Entry [row*4 + col]; listed from index 15 down to 0.
   localparam logic [15:0][3:0] KEY_TABLE = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // Segments {g,f,e,d,c,b,a}; codes 10-15 are blank.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
      7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
      7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
   };

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return KEY_TABLE[{row, col}];
   endfunction

   // Several rows low resolve to the lowest-numbered one.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder, active-high segments.
module seg7_decoder
   import keypad_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/keypad_scan_display.sv
// 4x4 keypad scanner with press/release debounce, plus a 3-digit multiplexed
// 7-segment display driver.
module keypad_scan_display
   import keypad_display_pkg::*;
#(
   parameter int SCAN_CYCLES     = 27000,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REFRESH_CYCLES  = 27000
)(
   input  logic        clk,
   input  logic        n_reset,
   input  logic [3:0]  filas_raw,
   input  logic [11:0] cdu,
   output logic [3:0]  columnas,
   output logic [3:0]  sample,
   output logic        key_valid,
   output logic [3:0]  key_pressed,
   output logic [6:0]  d,
   output logic [2:0]  a
);

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int REF_W   = $clog2(REFRESH_CYCLES + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

   logic [3:0]       r_filas_meta;
   logic [3:0]       r_filas_sync;
   logic [3:0]       r_rows_latched;
   scan_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_col;
   logic [3:0]       r_sample;
   logic             r_key_valid;
   logic [REF_W-1:0] r_ref_cnt;
   logic [1:0]       r_digit;
   logic             w_all_high;
   logic [3:0]       w_bcd;

   assign w_all_high = (r_filas_sync == 4'hF);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_filas_meta <= 4'hF;
         r_filas_sync <= 4'hF;
      end else begin
         r_filas_meta <= filas_raw;
         r_filas_sync <= r_filas_meta;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state        <= SCAN;
         r_cnt          <= '0;
         r_col          <= 2'd0;
         r_rows_latched <= 4'hF;
         r_sample       <= 4'h0;
         r_key_valid    <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         case (r_state)
            SCAN: begin
               if (!w_all_high) begin
                  r_state        <= DEBOUNCE_PRESS;
                  r_rows_latched <= r_filas_sync;
                  r_cnt          <= '0;
               end else if (r_cnt == SCAN_LAST) begin
                  r_cnt <= '0;
                  r_col <= r_col + 2'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DEBOUNCE_PRESS: begin
               // Any bounce abandons the candidate key; the column stays put.
               if (r_filas_sync != r_rows_latched) begin
                  r_state <= SCAN;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state     <= HELD;
                  r_cnt       <= '0;
                  r_sample    <= key_code(lowest_low_row(r_rows_latched), r_col);
                  r_key_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HELD: begin
               if (w_all_high) begin
                  r_state <= DEBOUNCE_RELEASE;
                  r_cnt   <= '0;
               end
            end
            DEBOUNCE_RELEASE: begin
               if (!w_all_high) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == DEB_LAST) begin
                  r_state <= SCAN;
                  r_cnt   <= '0;
                  r_col   <= r_col + 2'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= SCAN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_ref_cnt <= '0;
         r_digit   <= 2'd0;
      end else if (r_ref_cnt == REF_LAST) begin
         r_ref_cnt <= '0;
         r_digit   <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
      end else begin
         r_ref_cnt <= r_ref_cnt + 1'b1;
      end
   end

   always_comb begin
      w_bcd = cdu[3:0];
      case (r_digit)
         2'd1:    w_bcd = cdu[7:4];
         2'd2:    w_bcd = cdu[11:8];
         default: w_bcd = cdu[3:0];
      endcase
   end

   seg7_decoder u_seg7 (
      .bcd (w_bcd),
      .seg (d)
   );

   assign columnas    = ~(4'b0001 << r_col);
   assign sample      = r_sample;
   assign key_valid   = r_key_valid;
   assign key_pressed = (r_state == HELD) ? ~columnas : 4'b0000;
   assign a           = ~(3'b001 << r_digit);

endmodule

// File: tb/tb_keypad_scan_display.sv
// Directed bench for keypad_scan_display with short scan/debounce/refresh periods.
module tb_keypad_scan_display;

   logic        clk;
   logic        n_reset;
   logic [3:0]  filas_raw;
   logic [11:0] cdu;
   logic [3:0]  columnas;
   logic [3:0]  sample;
   logic        key_valid;
   logic [3:0]  key_pressed;
   logic [6:0]  d;
   logic [2:0]  a;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   keypad_scan_display #(
      .SCAN_CYCLES     (4),
      .DEBOUNCE_CYCLES (8),
      .REFRESH_CYCLES  (4)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .filas_raw   (filas_raw),
      .cdu         (cdu),
      .columnas    (columnas),
      .sample      (sample),
      .key_valid   (key_valid),
      .key_pressed (key_pressed),
      .d           (d),
      .a           (a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (key_valid) pulses++;
      end
   endtask

   // Returns at the first cycle in which the requested column is driven.
   task automatic wait_col(input logic [3:0] col);
      logic [3:0] prev;
      bit found;
      prev  = columnas;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (key_valid) pulses++;
         if (columnas == col && prev != col) found = 1'b1;
         prev = columnas;
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL wait_col: columnas=%b never reached %b", columnas, col);
      end
   endtask

   task automatic test_reset();
      n_reset   = 1'b0;
      filas_raw = 4'hF;
      cdu       = 12'h000;
      tick(3);
      checks++; if (columnas !== 4'b1110) begin errors++; $display("FAIL reset_columnas: got %b exp 1110", columnas); end
      checks++; if (sample !== 4'h0) begin errors++; $display("FAIL reset_sample: got %h exp 0", sample); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b exp 0", key_valid); end
      checks++; if (key_pressed !== 4'b0000) begin errors++; $display("FAIL reset_key_pressed: got %b exp 0000", key_pressed); end
      checks++; if (a !== 3'b110) begin errors++; $display("FAIL reset_a: got %b exp 110", a); end
      checks++; if (d !== 7'b0111111) begin errors++; $display("FAIL reset_d: got %b exp 0111111", d); end
      $display("test_reset done: columnas=%b a=%b d=%b", columnas, a, d);
   endtask

   task automatic test_scan();
      logic [3:0] exp_col;
      n_reset = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         case ((n / 4) % 4)
            0:       exp_col = 4'b1110;
            1:       exp_col = 4'b1101;
            2:       exp_col = 4'b1011;
            default: exp_col = 4'b0111;
         endcase
         checks++; if (columnas !== exp_col) begin errors++; $display("FAIL scan_columnas[%0d]: got %b exp %b", n, columnas, exp_col); end
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL scan_key_valid[%0d]: got %b exp 0", n, key_valid); end
      end
      $display("test_scan done: 16 cycles checked");
   endtask

   task automatic test_press();
      wait_col(4'b1011);
      pulses    = 0;
      filas_raw = 4'b1101;
      tick(20);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL press_pulses: got %0d exp 1", pulses); end
      checks++; if (sample !== 4'h6) begin errors++; $display("FAIL press_sample: got %h exp 6", sample); end
      checks++; if (key_pressed !== 4'b0100) begin errors++; $display("FAIL press_key_pressed: got %b exp 0100", key_pressed); end
      checks++; if (columnas !== 4'b1011) begin errors++; $display("FAIL press_columnas_frozen: got %b exp 1011", columnas); end
      filas_raw = 4'hF;
      tick(4);
      checks++; if (key_pressed !== 4'b0000) begin errors++; $display("FAIL release_debounce_key_pressed: got %b exp 0000", key_pressed); end
      filas_raw = 4'b1101;
      tick(6);
      checks++; if (key_pressed !== 4'b0100) begin errors++; $display("FAIL relapse_key_pressed: got %b exp 0100", key_pressed); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL relapse_pulses: got %0d exp 1", pulses); end
      filas_raw = 4'hF;
      tick(12);
      checks++; if (columnas !== 4'b0111) begin errors++; $display("FAIL release_next_column: got %b exp 0111", columnas); end
      checks++; if (key_pressed !== 4'b0000) begin errors++; $display("FAIL release_key_pressed: got %b exp 0000", key_pressed); end
      checks++; if (sample !== 4'h6 || pulses !== 1) begin errors++; $display("FAIL release_hold_sample: got %h/%0d exp 6/1", sample, pulses); end
      $display("test_press done: sample=%h pulses=%0d", sample, pulses);
   endtask

   task automatic test_glitch();
      wait_col(4'b1110);
      pulses    = 0;
      filas_raw = 4'b0111;
      tick(3);
      filas_raw = 4'hF;
      tick(9);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d exp 0", pulses); end
      checks++; if (columnas !== 4'b1101) begin errors++; $display("FAIL glitch_scan_resumes: got %b exp 1101", columnas); end
      checks++; if (sample !== 4'h6) begin errors++; $display("FAIL glitch_sample_kept: got %h exp 6", sample); end
      $display("test_glitch done: columnas=%b pulses=%0d", columnas, pulses);
   endtask

   task automatic test_multi_row();
      wait_col(4'b0111);
      pulses    = 0;
      filas_raw = 4'b1010;
      tick(14);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL multi_pulses: got %0d exp 1", pulses); end
      checks++; if (sample !== 4'hA) begin errors++; $display("FAIL multi_sample: got %h exp A", sample); end
      checks++; if (key_pressed !== 4'b1000) begin errors++; $display("FAIL multi_key_pressed: got %b exp 1000", key_pressed); end
      filas_raw = 4'hF;
      tick(14);
      checks++; if (key_pressed !== 4'b0000) begin errors++; $display("FAIL multi_release: got %b exp 0000", key_pressed); end
      $display("test_multi_row done: sample=%h", sample);
   endtask

   task automatic test_display();
      logic [2:0] prev_a;
      logic [2:0] exp_a;
      logic [6:0] exp_d;
      bit found;
      cdu    = 12'h125;
      prev_a = a;
      found  = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (a == 3'b110 && prev_a != 3'b110) found = 1'b1;
         prev_a = a;
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL display_sync: a=%b never entered 110", a);
      end
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         case (i / 4)
            0:       begin exp_a = 3'b110; exp_d = 7'b1101101; end
            1:       begin exp_a = 3'b101; exp_d = 7'b1011011; end
            default: begin exp_a = 3'b011; exp_d = 7'b0000110; end
         endcase
         checks++; if (a !== exp_a) begin errors++; $display("FAIL display_a[%0d]: got %b exp %b", i, a, exp_a); end
         checks++; if (d !== exp_d) begin errors++; $display("FAIL display_d[%0d]: got %b exp %b", i, d, exp_d); end
      end
      cdu = 12'h00B;
      @(negedge clk);
      checks++; if (a !== 3'b110) begin errors++; $display("FAIL blank_a: got %b exp 110", a); end
      checks++; if (d !== 7'b0000000) begin errors++; $display("FAIL blank_d: got %b exp 0000000", d); end
      $display("test_display done: cdu=%h a=%b d=%b", cdu, a, d);
   endtask

   task automatic test_reset_mid_debounce();
      wait_col(4'b1101);
      filas_raw = 4'b1110;
      tick(6);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      checks++; if (columnas !== 4'b1110) begin errors++; $display("FAIL midrst_columnas: got %b exp 1110", columnas); end
      checks++; if (sample !== 4'h0) begin errors++; $display("FAIL midrst_sample: got %h exp 0", sample); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_key_valid: got %b exp 0", key_valid); end
      checks++; if (key_pressed !== 4'b0000) begin errors++; $display("FAIL midrst_key_pressed: got %b exp 0000", key_pressed); end
      checks++; if (a !== 3'b110) begin errors++; $display("FAIL midrst_a: got %b exp 110", a); end
      filas_raw = 4'hF;
      tick(2);
      @(negedge clk);
      n_reset = 1'b1;
      pulses  = 0;
      tick(20);
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d exp 0", pulses); end
      checks++; if (sample !== 4'h0) begin errors++; $display("FAIL midrst_sample_after: got %h exp 0", sample); end
      wait_col(4'b1110);
      pulses    = 0;
      filas_raw = 4'b1011;
      tick(14);
      checks++; if (pulses !== 1) begin errors++; $display("FAIL fresh_press_pulses: got %0d exp 1", pulses); end
      checks++; if (sample !== 4'h7) begin errors++; $display("FAIL fresh_press_sample: got %h exp 7", sample); end
      filas_raw = 4'hF;
      tick(14);
      $display("test_reset_mid_debounce done: sample=%h", sample);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_press();
      test_glitch();
      test_multi_row();
      test_display();
      test_reset_mid_debounce();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
